// File: rtl/epg_misc_regbank_v2_if.sv
// APB-style slave bus bundle for the external peripheral group register bank.
// The master drives the request fields and the slave returns the response fields.
interface epg_misc_regbank_v2_if #(
  parameter int unsigned BW_ADDR = 8
);
  logic               rpsel;
  logic               rpenable;
  logic [BW_ADDR-1:0] rpaddr;
  logic               rpwrite;
  logic [31:0]        rpwdata;
  logic [3:0]         rpstrb;
  logic [31:0]        rprdata;
  logic               rpready;
  logic               rpslverr;

  modport master (
    output rpsel, rpenable, rpaddr, rpwrite, rpwdata, rpstrb,
    input  rprdata, rpready, rpslverr
  );

  modport slave (
    input  rpsel, rpenable, rpaddr, rpwrite, rpwdata, rpstrb,
    output rprdata, rpready, rpslverr
  );
endinterface

// File: rtl/epg_misc_regbank_v2.sv
// Register bank for the external peripheral group: general-purpose registers,
// sticky write-status bits with a maskable interrupt, and a programmable tick.
module epg_misc_regbank_v2 #(
  parameter int unsigned BW_ADDR          = 8,
  parameter int unsigned NUM_EXTREG       = 8,
  parameter int unsigned BW_TICK_CFG      = 16,
  parameter logic [31:0] EXTREG_DEFAULT   = 32'h0,
  parameter int unsigned TICK_CFG_DEFAULT = 0
) (
  input  logic                    clk,
  input  logic                    rstnn,
  epg_misc_regbank_v2_if.slave    apb,
  output logic [32*NUM_EXTREG-1:0] extreg_list,
  output logic [NUM_EXTREG-1:0]   extreg_wpulse,
  output logic [BW_TICK_CFG-1:0]  tick_cfg,
  output logic                    tick,
  output logic                    irq
);
  localparam int unsigned IDX_TICK   = NUM_EXTREG;
  localparam int unsigned IDX_STATUS = NUM_EXTREG + 1;
  localparam int unsigned IDX_IRQEN  = NUM_EXTREG + 2;

  logic                   w_access;
  logic                   w_err;
  logic                   w_wr;
  logic [31:0]            w_idx;
  logic [31:0]            w_bmask;
  logic [31:0]            w_rdata;
  logic                   w_tick;
  logic [NUM_EXTREG-1:0]  w_ext_wr;
  logic [NUM_EXTREG-1:0]  w_status_clr;

  logic [31:0]            r_extreg [NUM_EXTREG];
  logic [NUM_EXTREG-1:0]  r_wpulse;
  logic [NUM_EXTREG-1:0]  r_status;
  logic [NUM_EXTREG-1:0]  r_irq_en;
  logic [BW_TICK_CFG-1:0] r_tick_cfg;
  logic [BW_TICK_CFG-1:0] r_cnt;

  assign w_access = apb.rpsel & apb.rpenable;
  assign w_idx    = 32'(apb.rpaddr[BW_ADDR-1:2]);
  assign w_err    = w_access & ((apb.rpaddr[1:0] != 2'b00) | (w_idx > IDX_IRQEN));
  assign w_wr     = w_access & apb.rpwrite & ~w_err;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bmask
      assign w_bmask[8*gi +: 8] = {8{apb.rpstrb[gi]}};
    end
    for (gi = 0; gi < NUM_EXTREG; gi++) begin : g_ext
      assign w_ext_wr[gi]              = w_wr & (w_idx == 32'(gi));
      assign extreg_list[32*gi +: 32]  = r_extreg[gi];
    end
  endgenerate

  // Strobes gate the W1C mask byte-wise, like an ordinary write.
  assign w_status_clr = (w_wr && (w_idx == IDX_STATUS)) ?
                        (apb.rpwdata[NUM_EXTREG-1:0] & w_bmask[NUM_EXTREG-1:0]) : '0;

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      for (int unsigned k = 0; k < NUM_EXTREG; k++) r_extreg[k] <= EXTREG_DEFAULT;
      r_wpulse <= '0;
      r_status <= '0;
      r_irq_en <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_EXTREG; k++) begin
        if (w_ext_wr[k]) r_extreg[k] <= (r_extreg[k] & ~w_bmask) | (apb.rpwdata & w_bmask);
      end
      r_wpulse <= w_ext_wr;
      // Set is applied after clear so a simultaneous write keeps the bit.
      r_status <= (r_status & ~w_status_clr) | w_ext_wr;
      if (w_wr && (w_idx == IDX_IRQEN))
        r_irq_en <= (r_irq_en & ~w_bmask[NUM_EXTREG-1:0]) |
                    (apb.rpwdata[NUM_EXTREG-1:0] & w_bmask[NUM_EXTREG-1:0]);
    end
  end

  assign w_tick = (r_tick_cfg != '0) && (r_cnt == r_tick_cfg);

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      r_tick_cfg <= BW_TICK_CFG'(TICK_CFG_DEFAULT);
      r_cnt      <= '0;
    end else if (w_wr && (w_idx == IDX_TICK)) begin
      // Any config write restarts the phase, even with an unchanged value.
      r_tick_cfg <= (r_tick_cfg & ~w_bmask[BW_TICK_CFG-1:0]) |
                    (apb.rpwdata[BW_TICK_CFG-1:0] & w_bmask[BW_TICK_CFG-1:0]);
      r_cnt      <= '0;
    end else if (w_tick || (r_tick_cfg == '0)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + BW_TICK_CFG'(1);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_access && !w_err) begin
      if (w_idx < NUM_EXTREG) begin
        for (int unsigned k = 0; k < NUM_EXTREG; k++) begin
          if (w_idx == k) w_rdata = r_extreg[k];
        end
      end else if (w_idx == IDX_TICK) begin
        w_rdata = 32'(r_tick_cfg);
      end else if (w_idx == IDX_STATUS) begin
        w_rdata = 32'(r_status);
      end else begin
        w_rdata = 32'(r_irq_en);
      end
    end
  end

  assign apb.rprdata  = w_rdata;
  assign apb.rpready  = 1'b1;
  assign apb.rpslverr = w_err;

  assign extreg_wpulse = r_wpulse;
  assign tick_cfg      = r_tick_cfg;
  assign tick          = w_tick;
  assign irq           = |(r_status & r_irq_en);
endmodule

// File: tb/tb_epg_misc_regbank_v2.sv
// Directed bench for epg_misc_regbank_v2: bus responses go through a scoreboard
// queue checked by a monitor; side-band outputs are checked at fixed cycles.
module tb_epg_misc_regbank_v2;
  localparam int unsigned NUM = 8;
  localparam logic [31:0] DEF = 32'h1234_5678;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    bit          chk_data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstnn = 1'b0;
  logic [32*NUM-1:0] extreg_list;
  logic [NUM-1:0]  extreg_wpulse;
  logic [15:0]     tick_cfg;
  logic            tick;
  logic            irq;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  epg_misc_regbank_v2_if #(.BW_ADDR(8)) apb_if ();

  epg_misc_regbank_v2 #(
    .BW_ADDR(8), .NUM_EXTREG(NUM), .BW_TICK_CFG(16),
    .EXTREG_DEFAULT(DEF), .TICK_CFG_DEFAULT(0)
  ) dut (
    .clk(clk), .rstnn(rstnn), .apb(apb_if),
    .extreg_list(extreg_list), .extreg_wpulse(extreg_wpulse),
    .tick_cfg(tick_cfg), .tick(tick), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1);
  end

  // Monitor: every access phase consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (apb_if.rpsel && apb_if.rpenable && apb_if.rpready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_access: actual=access required=none");
        end else begin
          e = sb_q.pop_front();
          if ((apb_if.rpslverr !== e.err) || (e.chk_data && (apb_if.rprdata !== e.data))) begin
            n_errors++;
            $display("FAIL %s: actual rdata=%08h slverr=%b, required rdata=%08h slverr=%b",
                     e.name, apb_if.rprdata, apb_if.rpslverr, e.data, e.err);
          end else begin
            $display("ok   %s: rdata=%08h slverr=%b", e.name, apb_if.rprdata, apb_if.rpslverr);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input string name, input logic [31:0] exp_data,
                          input logic exp_err, input bit chk_data, input bit rst_in_access);
    exp_t e;
    apb_if.rpsel    = 1'b1;
    apb_if.rpenable = 1'b0;
    apb_if.rpaddr   = addr;
    apb_if.rpwrite  = wr;
    apb_if.rpwdata  = wdata;
    apb_if.rpstrb   = strb;
    @(posedge clk); #1;
    apb_if.rpenable = 1'b1;
    if (rst_in_access) rstnn = 1'b0;
    e.name = name; e.data = exp_data; e.err = exp_err; e.chk_data = chk_data;
    sb_q.push_back(e);
    @(posedge clk); #1;
    apb_if.rpsel    = 1'b0;
    apb_if.rpenable = 1'b0;
    rstnn           = 1'b1;
  endtask

  task automatic rd(input logic [7:0] addr, input string name, input logic [31:0] exp_data,
                    input logic exp_err);
    apb_xfer(1'b0, addr, 32'h0, 4'h0, name, exp_data, exp_err, 1'b1, 1'b0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input string name, input logic exp_err);
    apb_xfer(1'b1, addr, data, strb, name, 32'h0, exp_err, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [32*NUM-1:0] def_list;
    def_list = {NUM{DEF}};
    apb_if.rpsel = 1'b0; apb_if.rpenable = 1'b0; apb_if.rpaddr = '0;
    apb_if.rpwrite = 1'b0; apb_if.rpwdata = '0; apb_if.rpstrb = '0;

    // Reset and reset values
    repeat (3) @(posedge clk);
    #1 rstnn = 1'b1;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_wpulse", 32'(extreg_wpulse), 32'h0);
    chk("rst_slverr", 32'(apb_if.rpslverr), 32'h0);
    chk("rst_list_lo", extreg_list[31:0], DEF);
    chk("rst_list_hi", extreg_list[255:224], DEF);
    for (int k = 0; k < NUM; k++) rd(8'(4*k), $sformatf("rst_rd_ext%0d", k), DEF, 1'b0);
    rd(8'h20, "rst_rd_tickcfg", 32'h0, 1'b0);
    rd(8'h24, "rst_rd_status", 32'h0, 1'b0);
    rd(8'h28, "rst_rd_irqen", 32'h0, 1'b0);

    // Clear EXTREG3, then partial-strobe write
    wr(8'h0C, 32'h0, 4'hF, "wr_ext3_zero", 1'b0);
    wr(8'h24, 32'hFF, 4'hF, "w1c_all", 1'b0);
    rd(8'h24, "rd_status_cleared", 32'h0, 1'b0);
    wr(8'h0C, 32'hAABBCCDD, 4'b0101, "wr_ext3_strb", 1'b0);
    chk("wpulse3_on", 32'(extreg_wpulse), 32'h08);
    step();
    chk("wpulse3_off", 32'(extreg_wpulse), 32'h00);
    chk("list_ext3", extreg_list[96 +: 32], 32'h00BB00DD);
    rd(8'h0C, "rd_ext3", 32'h00BB00DD, 1'b0);
    rd(8'h24, "rd_status_8", 32'h8, 1'b0);

    // Interrupt enable and W1C
    chk("irq_pre_en", 32'(irq), 32'h0);
    wr(8'h28, 32'h8, 4'hF, "wr_irqen", 1'b0);
    chk("irq_set", 32'(irq), 32'h1);
    rd(8'h28, "rd_irqen", 32'h8, 1'b0);
    wr(8'h24, 32'h1, 4'hF, "w1c_bit0", 1'b0);
    chk("irq_still", 32'(irq), 32'h1);
    rd(8'h24, "rd_status_keep", 32'h8, 1'b0);
    wr(8'h24, 32'h8, 4'hF, "w1c_bit3", 1'b0);
    chk("irq_clear", 32'(irq), 32'h0);
    rd(8'h24, "rd_status_clr", 32'h0, 1'b0);

    // Zero-strobe write still counts; zero-strobe W1C clears nothing
    wr(8'h14, 32'hFFFFFFFF, 4'h0, "wr_ext5_nostrb", 1'b0);
    chk("wpulse5_on", 32'(extreg_wpulse), 32'h20);
    rd(8'h14, "rd_ext5_unchanged", DEF, 1'b0);
    rd(8'h24, "rd_status_20", 32'h20, 1'b0);
    wr(8'h24, 32'h20, 4'h0, "w1c_nostrb", 1'b0);
    rd(8'h24, "rd_status_still20", 32'h20, 1'b0);
    wr(8'h24, 32'h20, 4'h1, "w1c_strb0", 1'b0);
    rd(8'h24, "rd_status_0", 32'h0, 1'b0);

    // Tick generator
    wr(8'h20, 32'h3, 4'hF, "wr_tick3", 1'b0);
    chk("tick_cfg_3", 32'(tick_cfg), 32'h3);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tick_a_c%0d", i), 32'(tick), (i % 4 == 3) ? 32'h1 : 32'h0);
      step();
    end
    wr(8'h20, 32'h3, 4'hF, "wr_tick3_again", 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tick_b_c%0d", i), 32'(tick), (i % 4 == 3) ? 32'h1 : 32'h0);
      step();
    end
    wr(8'h20, 32'h0, 4'hF, "wr_tick0", 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tick_off_c%0d", i), 32'(tick), 32'h0);
      step();
    end

    // Error responses leave state untouched
    rd(8'h02, "rd_misaligned", 32'h0, 1'b1);
    wr(8'h02, 32'hDEADBEEF, 4'hF, "wr_misaligned", 1'b1);
    chk("err_no_pulse_a", 32'(extreg_wpulse), 32'h0);
    chk("err_ext0_keep", extreg_list[31:0], DEF);
    wr(8'h2C, 32'hFFFFFFFF, 4'hF, "wr_unmapped", 1'b1);
    chk("err_no_pulse_b", 32'(extreg_wpulse), 32'h0);
    rd(8'h2C, "rd_unmapped", 32'h0, 1'b1);
    rd(8'h24, "rd_status_after_err", 32'h0, 1'b0);
    rd(8'h28, "rd_irqen_after_err", 32'h8, 1'b0);

    // Reset during a write access with the tick running
    wr(8'h00, 32'h1, 4'hF, "wr_ext0", 1'b0);
    wr(8'h28, 32'h1, 4'hF, "wr_irqen_b0", 1'b0);
    chk("irq_before_rst", 32'(irq), 32'h1);
    wr(8'h20, 32'h5, 4'hF, "wr_tick5", 1'b0);
    step(); step();
    apb_xfer(1'b1, 8'h00, 32'hCAFEF00D, 4'hF, "wr_ext0_in_rst", 32'h0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_wpulse", 32'(extreg_wpulse), 32'h0);
    chk("mid_rst_tick_cfg", 32'(tick_cfg), 32'h0);
    chk("mid_rst_ext0", extreg_list[31:0], DEF);
    n_checks++;
    if (extreg_list !== def_list) begin
      n_errors++;
      $display("FAIL mid_rst_list: actual ext3=%08h required all=%08h", extreg_list[96 +: 32], DEF);
    end
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("mid_rst_tick_c%0d", i), 32'(tick), 32'h0);
      step();
    end
    rd(8'h24, "rd_status_after_rst", 32'h0, 1'b0);
    rd(8'h28, "rd_irqen_after_rst", 32'h0, 1'b0);
    rd(8'h00, "rd_ext0_after_rst", DEF, 1'b0);

    repeat (3) step();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
